// File: rtl/intersection_pkg.sv
// Shared types for the multi-phase intersection controller.
// Latency: n/a (types, lamp codes and a width helper only).
// Backpressure: n/a.
// Optional feature macro: INTERSECTION_FLASH_EN adds the FLASH state.
package intersection_pkg;

`ifdef INTERSECTION_FLASH_EN
   typedef enum logic [1:0] {
      ST_ALL_RED = 2'd0,
      ST_GREEN   = 2'd1,
      ST_YELLOW  = 2'd2,
      ST_FLASH   = 2'd3
   } state_e;
`else
   typedef enum logic [1:0] {
      ST_ALL_RED = 2'd0,
      ST_GREEN   = 2'd1,
      ST_YELLOW  = 2'd2
   } state_e;
`endif

   // Per-phase lamp encodings; 2'b11 is never driven.
   localparam logic [1:0] LIGHT_RED    = 2'b00;
   localparam logic [1:0] LIGHT_GREEN  = 2'b01;
   localparam logic [1:0] LIGHT_YELLOW = 2'b10;

   // Width of a phase index; never less than one bit.
   function automatic int phase_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/intersection_if.sv
// Signal bundle between demand-latch front end, controller and lamp driver.
// Latency: n/a (wires only).
// Backpressure: none; tick strobes the controller, served clears the latch.
// Ports: tick, demand[NUM_PHASES], served[NUM_PHASES], light[2*NUM_PHASES],
//        phase[clog2(NUM_PHASES)], flash (only with INTERSECTION_FLASH_EN).
interface intersection_if
   import intersection_pkg::*;
#(
   parameter int NUM_PHASES = 4
);
   localparam int PW = phase_w(NUM_PHASES);

   logic                    tick;
   logic [NUM_PHASES-1:0]   demand;
   logic [NUM_PHASES-1:0]   served;
   logic [2*NUM_PHASES-1:0] light;
   logic [PW-1:0]           phase;
`ifdef INTERSECTION_FLASH_EN
   logic                    flash;
`endif

`ifdef INTERSECTION_FLASH_EN
   // Front-end / environment side.
   modport master (output tick, demand, flash, input served, light, phase);
   // Controller side.
   modport slave  (input tick, demand, flash, output served, light, phase);
`else
   modport master (output tick, demand, input served, light, phase);
   modport slave  (input tick, demand, output served, light, phase);
`endif

endinterface

// File: rtl/intersection_rr_pick.sv
// Round-robin phase selector: first set demand bit after cur, wrapping to cur.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: demand, cur in; next_phase (cur+1 when demand is empty), any_other_demand out.
module intersection_rr_pick
   import intersection_pkg::*;
#(
   parameter int NUM_PHASES = 4,
   localparam int PW = phase_w(NUM_PHASES)
) (
   input  logic [NUM_PHASES-1:0] demand,
   input  logic [PW-1:0]         cur,
   output logic [PW-1:0]         next_phase,
   output logic                  any_other_demand
);

   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      // Fixed-time fallback when nobody is waiting.
      next_phase = PW'((int'(cur) + 1) % NUM_PHASES);
      found      = 1'b0;
      idx        = '0;
      // Offsets 1..NUM_PHASES so the current phase is considered last.
      for (int i = 1; i <= NUM_PHASES; i++) begin
         idx = PW'((int'(cur) + i) % NUM_PHASES);
         if (!found && demand[idx]) begin
            next_phase = idx;
            found      = 1'b1;
         end
      end
   end

   assign any_other_demand = |(demand & ~(NUM_PHASES'(1) << cur));

endmodule

// File: rtl/intersection_controller.sv
// Multi-phase traffic signal controller: round-robin with demand skipping,
// min/max green, timed yellow and all-red clearance, all counted in ticks.
// Latency: decisions registered; outputs change on the clk edge that completes an interval.
// Backpressure: none; tick=0 freezes all state; served pulses one cycle to clear the latch.
// Ports: clk, reset (async, active-high), bus (intersection_if.slave: tick, demand,
//        served, light, phase, and flash when INTERSECTION_FLASH_EN is defined).
module intersection_controller
   import intersection_pkg::*;
#(
   parameter int NUM_PHASES   = 4,
   parameter int CNT_W        = 8,
   parameter int MIN_GREEN    = 3,
   parameter int MAX_GREEN    = 6,
   parameter int YELLOW_TICKS = 2,
   parameter int ALLRED_TICKS = 1
) (
   input  logic        clk,
   input  logic        reset,
   intersection_if.slave bus
);

   localparam int PW = phase_w(NUM_PHASES);

   // Terminal timer values: a state of length L ends on the tick seen at L-1.
   localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
   localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN - 1);

   state_e                state_q,  state_d;
   logic [PW-1:0]         cur_q,    cur_d;
   logic [CNT_W-1:0]      timer_q,  timer_d;
   logic [NUM_PHASES-1:0] served_q, served_d;
`ifdef INTERSECTION_FLASH_EN
   logic                  flash_on_q, flash_on_d;  // 1 = lamps showing yellow
`endif

   logic [PW-1:0]           pick_phase;
   logic                    any_other;
   logic [2*NUM_PHASES-1:0] light_w;
   logic [1:0]              lamp;

   intersection_rr_pick #(
      .NUM_PHASES (NUM_PHASES)
   ) u_rr_pick (
      .demand           (bus.demand),
      .cur              (cur_q),
      .next_phase       (pick_phase),
      .any_other_demand (any_other)
   );

   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      timer_d  = timer_q;
      served_d = '0;
`ifdef INTERSECTION_FLASH_EN
      flash_on_d = flash_on_q;
`endif

      if (bus.tick) begin
         case (state_q)
            ST_ALL_RED: begin
               if (timer_q == ALLRED_LAST) begin
                  state_d  = ST_GREEN;
                  timer_d  = '0;
                  cur_d    = pick_phase;
                  served_d = NUM_PHASES'(1) << pick_phase;
               end else begin
                  timer_d = timer_q + CNT_W'(1);
               end
            end
            ST_GREEN: begin
               // Max green ends unconditionally; past min green, any
               // conflicting request ends it early.
               if ((timer_q == MAX_LAST) ||
                   ((timer_q >= MIN_LAST) && any_other)) begin
                  state_d = ST_YELLOW;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + CNT_W'(1);
               end
            end
            ST_YELLOW: begin
               if (timer_q == YELLOW_LAST) begin
                  state_d = ST_ALL_RED;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end

`ifdef INTERSECTION_FLASH_EN
      // Flash is sampled every clock and overrides any tick-driven transition,
      // including the served pulse of an all-red expiry on the same edge.
      if (bus.flash) begin
         state_d  = ST_FLASH;
         timer_d  = '0;
         served_d = '0;
         if (state_q == ST_FLASH) begin
            flash_on_d = bus.tick ? ~flash_on_q : flash_on_q;
         end else begin
            flash_on_d = 1'b1;
         end
      end else if (state_q == ST_FLASH) begin
         // Leave through a full clearance interval; cur is kept so the
         // round-robin resumes after the phase that was interrupted.
         state_d    = ST_ALL_RED;
         timer_d    = '0;
         flash_on_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_ALL_RED;
         cur_q    <= PW'(NUM_PHASES - 1);
         timer_q  <= '0;
         served_q <= '0;
`ifdef INTERSECTION_FLASH_EN
         flash_on_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         timer_q  <= timer_d;
         served_q <= served_d;
`ifdef INTERSECTION_FLASH_EN
         flash_on_q <= flash_on_d;
`endif
      end
   end

   // Lamp decode from registers only, so no input reaches light combinationally.
   always_comb begin
      light_w = '0;
      lamp    = LIGHT_RED;
      for (int p = 0; p < NUM_PHASES; p++) begin
         lamp = LIGHT_RED;
         if (cur_q == PW'(p)) begin
            if (state_q == ST_GREEN) begin
               lamp = LIGHT_GREEN;
            end else if (state_q == ST_YELLOW) begin
               lamp = LIGHT_YELLOW;
            end
         end
`ifdef INTERSECTION_FLASH_EN
         if (state_q == ST_FLASH) begin
            lamp = flash_on_q ? LIGHT_YELLOW : LIGHT_RED;
         end
`endif
         light_w[2*p +: 2] = lamp;
      end
   end

   assign bus.light  = light_w;
   assign bus.phase  = cur_q;
   assign bus.served = served_q;

endmodule

// File: doc/intersection_controller.md
# intersection_controller

Parametrised multi-phase traffic signal controller, the successor to the single-approach red/green/yellow sequencer. Serves NUM_PHASES conflicting phases in round-robin order with demand-based skipping, minimum/maximum green, timed yellow and an all-red clearance interval, all counted in external `tick` strobes. Sits between the demand-latch front end and the lamp driver.

## Interface
- NUM_PHASES, 4: number of conflicting phases, 2..8.
- CNT_W, 8: tick-counter width.
- MIN_GREEN, 3: minimum green length, in ticks (≥1).
- MAX_GREEN, 6: maximum green length, in ticks (≥MIN_GREEN, <2^CNT_W).
- YELLOW_TICKS, 2: yellow length, in ticks (≥1).
- ALLRED_TICKS, 1: all-red clearance length, in ticks (≥1).

- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- tick  in  1  one-cycle time-base strobe; every timer advances only on tick=1.
- demand  in  NUM_PHASES  level request per phase, held by the external latch.
- served  out  NUM_PHASES  one-cycle pulse on bit p when phase p enters GREEN; clears the latch.
- light  out  2*NUM_PHASES  per-phase lamp, light[2p+1:2p]: 00=red, 01=green, 10=yellow; 11 never driven.
- phase  out  clog2(NUM_PHASES)  currently/last served phase.
- flash  in  1  flash-mode request (only with INTERSECTION_FLASH_EN).

## Operation
- States: ALL_RED, GREEN, YELLOW (plus FLASH when configured). Registers: state, cur (phase), timer (CNT_W).
- Reset: state=ALL_RED, cur=NUM_PHASES-1, timer=0, served=0, all lights red, phase=NUM_PHASES-1.
- Timer: cleared on every state entry. On tick in a state of length L: if timer==L-1, transition; else timer+1. A state therefore lasts exactly L ticks.
- ALL_RED (L=ALLRED_TICKS) → GREEN. The next phase is the first set demand bit, searched round-robin from cur+1 wrapping to cur. If demand==0, cur+1 mod NUM_PHASES is served (fixed-time fallback). Set cur accordingly and pulse served[cur].
- GREEN: on tick, after timer has reached MIN_GREEN-1, go to YELLOW if any demand bit other than cur is set. Independently, go to YELLOW at timer==MAX_GREEN-1.
- YELLOW (L=YELLOW_TICKS) → ALL_RED.
- light: phase cur shows green/yellow in GREEN/YELLOW; all other phases are red. All phases are red in ALL_RED. light is a pure decode of registers, with no input-to-output combinational path.
- tick=0: all state, timer and outputs frozen; demand changes are only evaluated on tick cycles.
- Reset mid-operation: outputs go to their reset values immediately; any interval in progress is abandoned.

## Timing
- Decisions are registered: light, phase and served change on the clk edge where tick=1 completes an interval.
- served is high for exactly that cycle.
- Demand must be stable at the deciding tick edge. A demand bit rising on the same edge as the decision is ignored until the next decision.
- With tick every cycle, one full cycle with no demand is NUM_PHASES*(MAX_GREEN+YELLOW_TICKS+ALLRED_TICKS) clocks.

## Configuration
- INTERSECTION_FLASH_EN defined: the `flash` port and FLASH state exist.
  - flash=1, sampled each clk regardless of tick, forces FLASH from any state; flash wins over a simultaneous transition.
  - In FLASH, all lamps alternate 10/00, toggling on each tick and starting at 10.
  - On flash=0: enter ALL_RED with timer=0, cur unchanged, served not pulsed.
- Macro undefined: no port, no FLASH state; behaviour as above.

## Structure
- Package intersection_pkg: state enum, lamp encodings LIGHT_RED/LIGHT_GREEN/LIGHT_YELLOW, phase-index width function.
- Sub-module intersection_rr_pick: combinational round-robin selector (demand, cur → next phase, any_other_demand).

## Test plan
Setup: NUM_PHASES=4, MIN_GREEN=3, MAX_GREEN=6, YELLOW_TICKS=2, ALLRED_TICKS=1, tick=1 every cycle.
- Reset release, demand=0 → phases green in order 0,1,2,3,0. Each green lasts 6 clocks, each yellow 2, each all-red 1; served pulses 0001,0010,0100,1000.
- demand=4'b0100 held → only phase 2 is ever green, each time for 6 clocks; served=0100 once per 9-clock cycle; phases 0,1,3 stay red.
- Phase 0 green, demand[1] rises at green timer=0 → yellow after exactly 3 green clocks, then all-red, then phase 1 green.
- tick held low for 20 clocks mid-green → light, phase and timer unchanged; the interval resumes its remaining count afterwards.
- Reset asserted mid-yellow → all lights 00 asynchronously and phase=3; after release, phase 0 green after 1 tick.
- INTERSECTION_FLASH_EN: flash=1 during GREEN → all lamps 10,00,10 on successive ticks; flash=0 → 1 clock all-red, then round-robin resumes from cur+1.
